// File: rtl/irq_controller.sv
// Interrupt controller for the Bridge device bus.
// Latches device IRQ lines into PENDING, masks them and picks one source.
// It raises IRQ to the CPU and holds that source in service until the handler writes EOI.
// Ports: clk, reset (sync, active-high), Addr[31:2]/WE/Din/Dout (device bus, Addr[3:2] decoded),
//        irq_in (raw device lines), int_ack (CPU handler entry pulse),
//        IRQ (registered request), vector (registered source index).
// Optional: define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority with last_served in STATUS[18:16].
module irq_controller #(
    parameter int unsigned N_SRC = 6,
    parameter int unsigned VEC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:2]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic              int_ack,
    output logic              IRQ,
    output logic [VEC_W-1:0]  vector
);

    localparam logic [1:0] A_MASK    = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_STATUS  = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   r_irq_prev;
    logic [1:0]         r_ctrl;
    logic               r_irq;
    logic [VEC_W-1:0]   r_vector;

    logic               w_gen;
    logic               w_edge;
    logic               w_wr_mask;
    logic               w_wr_pend;
    logic               w_wr_status;
    logic               w_wr_ctrl;
    logic [N_SRC-1:0]   w_set;
    logic [N_SRC-1:0]   w_clr;
    logic [N_SRC-1:0]   w_pend_nxt;
    logic [N_SRC-1:0]   w_cand;
    logic [N_SRC-1:0]   w_vec_onehot;
    logic               w_abort;
    logic [VEC_W-1:0]   w_sel;
    logic               w_irq_nxt;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic               w_ack_clr;
    logic [31:0]        w_status;
    logic               w_unused;

    assign w_gen  = r_ctrl[0];
    assign w_edge = r_ctrl[1];

    // Bus write decode
    assign w_wr_mask   = WE && (Addr[3:2] == A_MASK);
    assign w_wr_pend   = WE && (Addr[3:2] == A_PENDING);
    assign w_wr_status = WE && (Addr[3:2] == A_STATUS);
    assign w_wr_ctrl   = WE && (Addr[3:2] == A_CTRL);

    assign w_unused = ^{Addr[31:4], Din[31:N_SRC]};

    // Request detection; set beats any same-cycle clear
    assign w_set        = w_edge ? (irq_in & ~r_irq_prev) : irq_in;
    assign w_vec_onehot = N_SRC'(1) << r_vector;
    assign w_clr        = (w_wr_pend ? Din[N_SRC-1:0] : '0) | (w_ack_clr ? w_vec_onehot : '0);
    assign w_pend_nxt   = (r_pending & ~w_clr) | w_set;

    assign w_cand  = r_pending & r_mask;
    assign w_abort = !w_gen || ((w_cand & w_vec_onehot) == '0);

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [VEC_W-1:0]   r_last;
    logic [VEC_W-1:0]   w_rr_start;
    int unsigned        w_idx;

    // Rotating priority: search from last_served+1 and wrap
    always_comb begin
        w_sel      = '0;
        w_idx      = 0;
        w_rr_start = (r_last == VEC_W'(N_SRC - 1)) ? '0 : (r_last + VEC_W'(1));
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = 32'(w_rr_start) + 32'(k);
            if (w_idx >= N_SRC) begin
                w_idx = w_idx - N_SRC;
            end
            if (((w_cand >> w_idx) & N_SRC'(1)) != '0) begin
                w_sel = VEC_W'(w_idx);
            end
        end
    end
`else
    // Fixed priority: lowest index wins
    always_comb begin
        w_sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel = VEC_W'(i);
            end
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; int_ack in REQ takes precedence over abort
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_gen && (w_cand != '0)) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nxt = ST_SERVICE;
                end else if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: if (w_wr_status) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: next IRQ/vector and the ack-driven pending clear
    always_comb begin
        w_irq_nxt = r_irq;
        w_vec_nxt = r_vector;
        w_ack_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gen && (w_cand != '0)) begin
                    w_irq_nxt = 1'b1;
                    w_vec_nxt = w_sel;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_irq_nxt = 1'b0;
                    w_ack_clr = 1'b1;
                end else if (w_abort) begin
                    w_irq_nxt = 1'b0;
                end
            end
            default: w_irq_nxt = 1'b0;
        endcase
    end

    // Register file and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_pending  <= '0;
            r_irq_prev <= '0;
            r_ctrl     <= '0;
            r_irq      <= 1'b0;
            r_vector   <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            r_last     <= VEC_W'(N_SRC - 1);
`endif
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= w_pend_nxt;
            if (w_wr_mask) r_mask <= Din[N_SRC-1:0];
            if (w_wr_ctrl) r_ctrl <= Din[1:0];
            r_irq      <= w_irq_nxt;
            r_vector   <= w_vec_nxt;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            if (w_ack_clr) r_last <= r_vector;
`endif
        end
    end

    assign IRQ    = r_irq;
    assign vector = r_vector;

    // Read mux
    always_comb begin
        w_status                = '0;
        w_status[9:8]           = r_state;
        w_status[VEC_W-1:0]     = r_vector;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
        w_status[18:16]         = 3'(r_last);
`endif
        Dout = '0;
        case (Addr[3:2])
            A_MASK:    Dout = 32'(r_mask);
            A_PENDING: Dout = 32'(r_pending);
            A_STATUS:  Dout = w_status;
            A_CTRL:    Dout = 32'(r_ctrl);
            default:   Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, raise/ack/EOI, priority, mask abort,
// level mode set-wins, and reset during service.
module tb_irq_controller;

    localparam int unsigned N_SRC = 6;
    localparam int unsigned VEC_W = 3;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:2]       addr = '0;
    logic              we = 1'b0;
    logic [31:0]       din = '0;
    logic [31:0]       dout;
    logic [N_SRC-1:0]  irq_in = '0;
    logic              int_ack = 1'b0;
    logic              irq;
    logic [VEC_W-1:0]  vector;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    irq_controller #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (addr),
        .WE      (we),
        .Din     (din),
        .Dout    (dout),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .IRQ     (irq),
        .vector  (vector)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        addr = 30'(a);
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        din  = '0;
    endtask

    task automatic set_addr(input int a);
        addr = 30'(a);
        #1;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %0b want 0", irq); else n_pass++;
        n_total++; if (vector !== 3'd0) $display("FAIL reset_vector: got %0d want 0", vector); else n_pass++;
        set_addr(0);
        n_total++; if (dout !== 32'h0) $display("FAIL reset_mask: got %h want 0", dout); else n_pass++;
        set_addr(1);
        n_total++; if (dout !== 32'h0) $display("FAIL reset_pending: got %h want 0", dout); else n_pass++;
        set_addr(3);
        n_total++; if (dout !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", dout); else n_pass++;
    endtask

    task automatic test_raise();
        bus_wr(0, 32'h3F);
        bus_wr(3, 32'h3);
        irq_in = 6'b000010;
        tick();
        irq_in = '0;
        set_addr(1);
        n_total++; if (dout !== 32'h02) $display("FAIL raise_pending: got %h want 02", dout); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL raise_irq_early: got %0b want 0", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL raise_irq: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== 3'd1) $display("FAIL raise_vector: got %0d want 1", vector); else n_pass++;
        set_addr(2);
        n_total++; if ((dout & 32'h3FF) !== 32'h101) $display("FAIL raise_status: got %h want 101", dout & 32'h3FF); else n_pass++;
    endtask

    task automatic test_ack_eoi();
        ack_pulse();
        n_total++; if (irq !== 1'b0) $display("FAIL ack_irq: got %0b want 0", irq); else n_pass++;
        set_addr(1);
        n_total++; if (dout !== 32'h0) $display("FAIL ack_pending: got %h want 0", dout); else n_pass++;
        set_addr(2);
        n_total++; if ((dout & 32'h3FF) !== 32'h201) $display("FAIL ack_status: got %h want 201", dout & 32'h3FF); else n_pass++;
        bus_wr(2, 32'h0);
        set_addr(2);
        n_total++; if ((dout & 32'h3FF) !== 32'h001) $display("FAIL eoi_status: got %h want 001", dout & 32'h3FF); else n_pass++;
    endtask

    task automatic test_priority();
        logic [VEC_W-1:0] exp_first;
        logic [VEC_W-1:0] exp_second;
        exp_first  = RR ? 3'd2 : 3'd0;
        exp_second = RR ? 3'd0 : 3'd2;
        irq_in = 6'b000101;
        tick();
        irq_in = '0;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL prio_irq1: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== exp_first) $display("FAIL prio_first: got %0d want %0d", vector, exp_first); else n_pass++;
        ack_pulse();
        bus_wr(2, 32'h0);
        n_total++; if (irq !== 1'b0) $display("FAIL b2b_gap: got %0b want 0", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL prio_irq2: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== exp_second) $display("FAIL prio_second: got %0d want %0d", vector, exp_second); else n_pass++;
        ack_pulse();
        bus_wr(2, 32'h0);
        set_addr(1);
        n_total++; if (dout !== 32'h0) $display("FAIL prio_pending_empty: got %h want 0", dout); else n_pass++;
    endtask

    task automatic test_mask_abort();
        irq_in = 6'b001000;
        tick();
        irq_in = '0;
        tick();
        n_total++; if (vector !== 3'd3) $display("FAIL abort_vector: got %0d want 3", vector); else n_pass++;
        bus_wr(0, 32'h37);
        n_total++; if (irq !== 1'b1) $display("FAIL abort_irq_hold: got %0b want 1", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b0) $display("FAIL abort_irq_drop: got %0b want 0", irq); else n_pass++;
        set_addr(2);
        n_total++; if ((dout & 32'h3FF) !== 32'h003) $display("FAIL abort_status: got %h want 003", dout & 32'h3FF); else n_pass++;
        set_addr(1);
        n_total++; if (dout !== 32'h08) $display("FAIL abort_pending: got %h want 08", dout); else n_pass++;
        bus_wr(0, 32'h3F);
        n_total++; if (irq !== 1'b0) $display("FAIL unmask_irq_early: got %0b want 0", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL unmask_irq: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== 3'd3) $display("FAIL unmask_vector: got %0d want 3", vector); else n_pass++;
        ack_pulse();
        bus_wr(2, 32'h0);
    endtask

    task automatic test_level_set_wins();
        bus_wr(3, 32'h1);
        irq_in = 6'b010000;
        tick();
        n_total++; if (irq !== 1'b0) $display("FAIL level_irq_early: got %0b want 0", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL level_irq: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== 3'd4) $display("FAIL level_vector: got %0d want 4", vector); else n_pass++;
        ack_pulse();
        set_addr(1);
        n_total++; if (dout !== 32'h10) $display("FAIL level_set_wins: got %h want 10", dout); else n_pass++;
        set_addr(2);
        n_total++; if ((dout & 32'h300) !== 32'h200) $display("FAIL level_service: got %h want 200", dout & 32'h300); else n_pass++;
        irq_in = '0;
        bus_wr(2, 32'h0);
        n_total++; if (irq !== 1'b0) $display("FAIL level_gap: got %0b want 0", irq); else n_pass++;
        tick();
        n_total++; if (irq !== 1'b1) $display("FAIL level_reassert: got %0b want 1", irq); else n_pass++;
        n_total++; if (vector !== 3'd4) $display("FAIL level_revector: got %0d want 4", vector); else n_pass++;
        ack_pulse();
    endtask

    task automatic test_reset_in_service();
        logic [31:0] exp_status;
        exp_status = RR ? 32'h0005_0000 : 32'h0;
        irq_in = 6'b100001;
        tick();
        irq_in = '0;
        set_addr(1);
        n_total++; if (dout !== 32'h21) $display("FAIL svc_pending: got %h want 21", dout); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL svc_irq: got %0b want 0", irq); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++; if (irq !== 1'b0) $display("FAIL rst_irq: got %0b want 0", irq); else n_pass++;
        set_addr(1);
        n_total++; if (dout !== 32'h0) $display("FAIL rst_pending: got %h want 0", dout); else n_pass++;
        set_addr(0);
        n_total++; if (dout !== 32'h0) $display("FAIL rst_mask: got %h want 0", dout); else n_pass++;
        set_addr(3);
        n_total++; if (dout !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", dout); else n_pass++;
        set_addr(2);
        n_total++; if (dout !== exp_status) $display("FAIL rst_status: got %h want %h", dout, exp_status); else n_pass++;
        bus_wr(2, 32'h0);
        ack_pulse();
        set_addr(2);
        n_total++; if (dout !== exp_status) $display("FAIL rst_eoi_ignored: got %h want %h", dout, exp_status); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL rst_irq_after: got %0b want 0", irq); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_raise();
        test_ack_eoi();
        test_priority();
        test_mask_abort();
        test_level_set_wins();
        test_reset_in_service();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name:
irq_controller

Overview:
- Memory-mapped interrupt controller between the device IRQ lines (Timer0, Timer1, external interrupt) and the CPU's interrupt input.
- Latches requests into a pending register and masks them.
- Picks one source by priority, raises a single interrupt to the CPU, and holds that source in service until the handler writes end-of-interrupt (EOI).
- Attaches to the Bridge as an extra device slot using the same Addr/WE/Din/Dout device interface as the timers.

Parameters:
- N_SRC, 6: number of interrupt sources, 1..8; bit i = source i.
- VEC_W, 3: width of the vector (source index) field.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- Addr  input  30 (bits 31:2)  device word address; only Addr[3:2] is decoded.
- WE  input  1  register write enable from Bridge.
- Din  input  32  write data.
- Dout  output  32  read data, combinational on Addr[3:2].
- irq_in  input  N_SRC  raw device interrupt lines.
- int_ack  input  1  one-cycle pulse from the CPU when it enters the handler.
- IRQ  output  1  interrupt request to the CPU, registered.
- vector  output  VEC_W  index of the selected source, registered.

Behaviour:
- Register map, by Addr[3:2]:
  - 0 = MASK (RW, [N_SRC-1:0]; 1 = enabled).
  - 1 = PENDING (read; writing 1 clears that bit, W1C).
  - 2 = STATUS (read: [9:8] = state code, [VEC_W-1:0] = vector; any write = EOI).
  - 3 = CTRL (RW: bit0 GEN global enable, bit1 EDGE = 1 for rising-edge detect, 0 for level).
- Unused read bits return 0.
- Reset effect, applied at the first clk edge with reset=1:
  - MASK=0, PENDING=0, CTRL=0, irq_prev=0.
  - state=IDLE, IRQ=0, vector=0.
  - Dout follows the registers, so it reads 0.
- Detection, every edge:
  - EDGE=1: pending[i] is set when irq_in[i]=1 and irq_prev[i]=0.
  - EDGE=0: pending[i] is set whenever irq_in[i]=1.
  - irq_prev <= irq_in on every edge.
- Simultaneous set and clear of the same pending bit (W1C write or ack) in one cycle: set wins.
- Eligible set: cand = PENDING & MASK.
- Selection: fixed priority, lowest index wins.
- State machine, state codes IDLE=0, REQ=1, SERVICE=2:
  - IDLE -> REQ when GEN=1 and cand!=0. On that edge, vector <= selected index and IRQ <= 1. IRQ therefore rises one cycle after the pending bit becomes visible.
  - REQ -> SERVICE on int_ack=1. On that edge, pending[vector] is cleared (subject to set-wins) and IRQ <= 0.
  - REQ -> IDLE when GEN=0 or the selected source is no longer in cand (masked or W1C-cleared). IRQ <= 0 and pending is untouched. The int_ack check takes precedence over this abort in the same cycle.
  - REQ holds vector stable. A higher-priority arrival does not preempt it.
  - SERVICE -> IDLE on a write to STATUS (EOI). vector holds its value.
  - In SERVICE, new requests only accumulate in PENDING.
  - EOI writes in IDLE or REQ are ignored.
  - int_ack in IDLE or SERVICE is ignored.
- Back-to-back requests: after EOI, the next eligible source is raised no earlier than the edge following the IDLE cycle, so IRQ stays low for at least one full cycle.
- Register writes take effect at the edge of the write. A MASK write and a REQ->IDLE abort evaluate against the pre-write MASK. The abort takes effect one cycle later.
- Reset asserted mid-operation (REQ or SERVICE) returns everything to reset values on that edge. No residual IRQ.

Optional Feature:
- Macro: IRQ_CTRL_ROUND_ROBIN_EN.
- Defined:
  - Selection uses rotating priority: search starts at index (last_served+1) mod N_SRC and wraps.
  - last_served is a VEC_W register, reset to N_SRC-1, so source 0 is favoured first.
  - last_served <= vector on the REQ->SERVICE transition.
  - STATUS[18:16] reads last_served.
- Undefined: fixed lowest-index priority; STATUS[18:16] reads 0.

Test Plan:
- Reset, then MASK=0x3F, CTRL=0x3, pulse irq_in[1] for one cycle -> PENDING=0x02 next edge; IRQ=1 and vector=1 one edge later; STATUS reads 0x101.
- In REQ with vector=1, pulse int_ack -> IRQ=0, PENDING=0x00, STATUS[9:8]=2; write STATUS -> state IDLE, STATUS reads 0x001.
- Set pending bits 0 and 2 in the same cycle, fixed priority -> vector=0 first; after ack+EOI, vector=2. With IRQ_CTRL_ROUND_ROBIN_EN and last_served=0 -> vector=2 first.
- In REQ with vector=3, write MASK=0x37 -> IRQ drops next edge, state IDLE, PENDING bit3 still 1; restore MASK=0x3F -> IRQ reasserts with vector=3.
- Level mode (CTRL=0x1), hold irq_in[4]=1 through ack -> PENDING bit4 re-set the same edge (set wins); after EOI, IRQ reasserts with vector=4.
- Assert reset while in SERVICE with PENDING=0x21 -> next edge IRQ=0, PENDING=0, MASK=0, CTRL=0, STATUS=0; EOI write afterwards has no effect.
